uart_tx_core: RTL
=================

Name: uart_tx_core

Overview:
- UART transmitter; the transmit-direction counterpart of the oversampling UART receiver in the same system.
- Accepts a parallel byte with a one-cycle valid strobe and serialises it LSB-first on TX_OUT.
- Frame: start bit, data bits, optional parity bit, one stop bit.
- Clocked by the baud-rate transmit clock from the clock divider: one CLK period equals one bit time. No oversampling.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.

Ports:
- CLK  input  1  transmit clock, one bit time per period.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel data; sampled only on the accept edge.
- DATA_VALID  input  1  request strobe; a frame is accepted when this is high on a CLK edge where the block is able to accept.
- PAR_EN  input  1  parity enable; sampled on the accept edge.
- PAR_TYP  input  1  parity type: 0 = even, 1 = odd; sampled on the accept edge.
- TX_OUT  output  1  serial line, registered; idles high.
- Busy  output  1  registered; high while a frame is on the line.

Behaviour:
- Reset: RST=1 forces, asynchronously, state=IDLE, TX_OUT=1, Busy=0, bit counter=0, data/parity/config latches=0.
- States: IDLE, START, DATA, PARITY, STOP. Each non-IDLE state lasts exactly one CLK per bit.
- Accept condition: DATA_VALID=1 at a CLK edge while state is IDLE, or while state is STOP (back-to-back transmission).
- On the accept edge:
  - Latch P_DATA, PAR_EN and PAR_TYP.
  - Compute parity bit = (^P_DATA) XOR PAR_TYP, so the parity bit for odd = ~(^P_DATA).
  - Go to START.
- Latency: TX_OUT=0 and Busy=1 in the cycle immediately after the accept edge.
- Transitions:
  - IDLE -> START on accept; otherwise stay in IDLE with TX_OUT=1 and Busy=0.
  - START -> DATA; TX_OUT=0.
  - DATA: TX_OUT = data[bit_cnt] with bit_cnt running 0..DATA_WIDTH-1, i.e. LSB first.
  - DATA exit on the last bit: go to PARITY if latched PAR_EN=1, else to STOP.
  - PARITY -> STOP; TX_OUT = latched parity bit.
  - STOP: TX_OUT=1. Go to START if accept occurs on this edge, else to IDLE.
- Frame length: DATA_WIDTH+2 cycles (10 at default) without parity; DATA_WIDTH+3 (11) with parity.
- Busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE. Busy stays continuously high across back-to-back frames.
- DATA_VALID in START, DATA or PARITY is ignored: no queueing, no effect on the frame in flight.
- Changes to P_DATA, PAR_EN or PAR_TYP after the accept edge do not affect the current frame.
- bit_cnt width is $clog2(DATA_WIDTH). It resets to 0 on entry to START.
- Reset mid-frame: the frame is abandoned immediately, TX_OUT=1, Busy=0. The first accept after release starts a complete new frame.
- TX_OUT and Busy come from flops only; no combinational path from inputs to outputs.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4);
  - PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, uart_tx_serializer:
  - load from the FSM loads the data register;
  - shift_en advances the data register and bit counter;
  - ser_data gives the current bit;
  - ser_done is high on the last data bit.
- The FSM, parity latch and output mux stay in uart_tx_core.

Test Plan:
1. Reset, then DATA_VALID pulse with P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1 (parity bit 0); Busy high for exactly those 11 cycles, then TX_OUT=1 and Busy=0.
2. P_DATA=8'h01, PAR_EN=1, PAR_TYP=1 -> TX_OUT = 0,1,0,0,0,0,0,0,0,0,1 (odd parity bit 0); then P_DATA=8'h00 odd -> parity bit 1.
3. P_DATA=8'hFF, PAR_EN=0 -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1; no parity cycle; Busy high for 10 cycles.
4. Back-to-back: DATA_VALID held high during the STOP cycle with P_DATA=8'h3C -> the next cycle is a start bit (TX_OUT=0); Busy never drops between frames; second frame bits match 8'h3C.
5. Mid-frame interference: during the DATA state, pulse DATA_VALID with P_DATA=8'hFF and toggle PAR_TYP -> first frame is unchanged, and no second frame is sent after STOP.
6. Reset mid-frame: assert RST during data bit 3 -> TX_OUT=1 and Busy=0 immediately, without waiting for a CLK edge; after release, an 8'h5A frame is transmitted in full and correctly.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encoding and line constants for the UART transmitter
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// rtl/uart_tx_core_if.sv - byte request and serial line bundle for uart_tx_core
interface uart_tx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - LSB-first data shift register with bit counter
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift_en,
    output logic                  o_ser_data,
    output logic                  o_ser_done
);
    localparam int               CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_done;

    // r_cnt indexes the bit being placed on the line; r_done marks that the last one is out
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (i_load) begin
            r_shift <= i_data;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= i_shift_en && (r_cnt == LAST);
            if (i_shift_en) begin
                r_shift <= r_shift >> 1;
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    assign o_ser_data = r_shift[0];
    assign o_ser_done = r_done;

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - UART transmitter: start, data, optional parity, stop at one bit per clock
module uart_tx_core
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_core_if.slave  bus
);
    tx_state_t r_state;
    tx_state_t w_next_state;

    logic w_accept;
    logic w_shift_en;
    logic w_ser_data;
    logic w_ser_done;
    logic w_tx_next;
    logic w_busy_next;

    logic r_par_en;
    logic r_par_bit;
    logic r_tx_out;
    logic r_busy;

    assign w_accept = bus.DATA_VALID && ((r_state == IDLE) || (r_state == STOP));

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_load     (w_accept),
        .i_data     (bus.P_DATA),
        .i_shift_en (w_shift_en),
        .o_ser_data (w_ser_data),
        .o_ser_done (w_ser_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Line value is chosen from the next state so TX_OUT/Busy leave flops aligned with the state
    always_comb begin
        w_next_state = IDLE;
        w_tx_next    = STOP_BIT;
        case (r_state)
            IDLE:    w_next_state = w_accept ? START : IDLE;
            START:   w_next_state = DATA;
            DATA: begin
                if (w_ser_done) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end else begin
                    w_next_state = DATA;
                end
            end
            PARITY:  w_next_state = STOP;
            STOP:    w_next_state = w_accept ? START : IDLE;
            default: w_next_state = IDLE;
        endcase

        case (w_next_state)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_ser_data;
            PARITY:  w_tx_next = r_par_bit;
            default: w_tx_next = STOP_BIT;
        endcase

        w_busy_next = (w_next_state != IDLE);
        w_shift_en  = (w_next_state == DATA);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_out  <= STOP_BIT;
            r_busy    <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_tx_out <= w_tx_next;
            r_busy   <= w_busy_next;
            if (w_accept) begin
                r_par_en  <= bus.PAR_EN;
                r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
            end
        end
    end

    assign bus.TX_OUT = r_tx_out;
    assign bus.Busy   = r_busy;

endmodule
